// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back select for the RV32I core.
// Write-port outputs depend only on posedge state, so they settle before the negedge register-file write.
module mem_wb_stage #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            mem_valid,
  input  logic            mem_reg_write,
  input  logic [4:0]      mem_rd,
  input  logic [1:0]      mem_wd_sel,
  input  logic [2:0]      mem_funct3,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [XLEN-1:0] mem_pc,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_pc,
  output logic [63:0]     instret
);

  logic            valid_q;
  logic            reg_write_q;
  logic [4:0]      rd_q;
  logic [1:0]      wd_sel_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] alu_q;
  logic [XLEN-1:0] rdata_q;
  logic [XLEN-1:0] pc_q;
  logic [63:0]     instret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= 5'd0;
      wd_sel_q    <= 2'b00;
      funct3_q    <= 3'b000;
      alu_q       <= '0;
      rdata_q     <= '0;
      pc_q        <= RESET_PC;
      instret_q   <= 64'd0;
    end else if (flush) begin
      // Only the bubble-defining bits change; payload fields keep their values.
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (!stall) begin
      valid_q     <= mem_valid;
      reg_write_q <= mem_reg_write & mem_valid;
      rd_q        <= mem_rd;
      wd_sel_q    <= mem_wd_sel;
      funct3_q    <= mem_funct3;
      alu_q       <= mem_alu_result;
      rdata_q     <= mem_rdata;
      pc_q        <= mem_pc;
      if (mem_valid) begin
        instret_q <= instret_q + 64'd1;
      end
    end
  end

  logic [1:0]      off;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] load_data;

  always_comb begin
    off       = alu_q[1:0];
    ld_byte   = rdata_q[8*off +: 8];
    ld_half   = off[1] ? rdata_q[31:16] : rdata_q[15:0];
    load_data = rdata_q;
    case (funct3_q)
      3'b000:  load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001:  load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, ld_half};
      default: load_data = rdata_q;
    endcase
  end

  always_comb begin
    rf_wdata = alu_q;
    case (wd_sel_q)
      2'b01:   rf_wdata = load_data;
      2'b10:   rf_wdata = pc_q + XLEN'(4);
      default: rf_wdata = alu_q;
    endcase
  end

  assign rf_we    = valid_q & reg_write_q & (rd_q != 5'd0);
  assign rf_waddr = rd_q;
  assign wb_valid = valid_q;
  assign wb_pc    = pc_q;
  assign instret  = instret_q;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus write-back logic of the 5-stage pipelined RV32I core.
- Captures MEM-stage results on posedge clk.
- Extracts and extends load data, selects the write-back value, and drives the register-file write port (RFWr/A3/WD).
- The register file writes on negedge clk, so every write-port output here comes from posedge-registered state and is stable half a cycle before the write.
- Also keeps the retired-instruction counter.

Parameters:
- XLEN, 32, datapath width.
- RESET_PC, 32'h0000_0000, reset value of wb_pc.

Ports:
- clk  input  1  system clock; state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- stall  input  1  hold all WB registers.
- flush  input  1  insert a bubble into WB.
- mem_valid  input  1  MEM stage holds a real instruction.
- mem_reg_write  input  1  instruction writes rd.
- mem_rd  input  5  destination register number.
- mem_wd_sel  input  2  write-back source: 00 = ALU, 01 = load, 10 = PC+4, 11 = ALU.
- mem_funct3  input  3  load type.
- mem_alu_result  input  XLEN  ALU result / load byte address.
- mem_rdata  input  XLEN  word-aligned data-memory read word.
- mem_pc  input  XLEN  instruction PC.
- rf_we  output  1  register-file write enable (RFWr).
- rf_waddr  output  5  register-file write address (A3).
- rf_wdata  output  XLEN  register-file write data (WD); also the forwarding source.
- wb_valid  output  1  WB holds a valid instruction.
- wb_pc  output  XLEN  PC of the WB instruction.
- instret  output  64  retired-instruction count.

Behaviour:
- Reset (async, rst=1): every WB register clears immediately.
  - valid=0, reg_write=0, rd=0, wd_sel=00, funct3=000, alu=0, rdata=0.
  - wb_pc=RESET_PC, instret=0.
  - Outputs: rf_we=0, rf_waddr=0, rf_wdata=0, wb_valid=0.
  - Reset mid-operation drops the in-flight instruction; no write occurs.
- Capture (posedge, rst=0), priority flush > stall > load:
  - flush=1: valid<=0 and reg_write<=0. Other fields are don't-care but hold their values. instret is unchanged.
  - flush=0, stall=1: all registers hold. rf_we stays as-is, so the register file rewrites the same value on each negedge (idempotent).
  - Otherwise: all mem_* inputs are loaded. valid<=mem_valid; reg_write<=mem_reg_write & mem_valid.
- Latency: one cycle. Inputs present before posedge N appear on the outputs after posedge N. The register-file write happens at the negedge inside cycle N.
- rf_we = valid & reg_write & (rd != 0). An x0 write never asserts rf_we.
- rf_waddr = rd.
- rf_wdata is combinational from registered state only, with no input-to-output path:
  - wd_sel 00/11: alu.
  - wd_sel 10: pc + 4, 32-bit wrap (pc=FFFF_FFFC gives 0).
  - wd_sel 01: load extraction with off = alu[1:0]:
    - LB (000): sign-extend byte rdata[8*off+7 : 8*off].
    - LBU (100): zero-extend the same byte.
    - LH (001): sign-extend rdata[31:16] if off[1] else rdata[15:0]; off[0] ignored.
    - LHU (101): zero-extend the same halfword.
    - LW (010) and any other funct3: rdata unchanged.
- wb_valid = valid. wb_pc = registered pc.
- instret:
  - +1 at posedge when flush=0, stall=0, mem_valid=1.
  - Wraps FFFF_FFFF_FFFF_FFFF -> 0.
  - Counts valid instructions regardless of mem_reg_write.

Test Plan:
- Reset mid-stream: assert rst between edges while wb_valid=1, rd=5 -> rf_we=0, instret=0, wb_pc=RESET_PC immediately, before the next edge.
- ALU write: mem_valid=1, reg_write=1, rd=3, sel=00, alu=1234_5678 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=1234_5678, instret=1. With rd=0 -> rf_we=0 and instret still increments.
- Loads on rdata=8081_F27F:
  - LB off=0 -> 0000_007F; LB off=1 -> FFFF_FFF2; LBU off=3 -> 0000_0080.
  - LH off=2 -> FFFF_8081; LHU off=0 -> 0000_F27F; LW -> 8081_F27F.
- JAL link: sel=10, pc=0000_0100 -> rf_wdata=0000_0104. pc=FFFF_FFFC -> 0000_0000.
- Stall/flush: load rd=7, then stall=1 for 3 cycles with changing inputs -> outputs unchanged and instret unchanged. Then flush=1 together with stall=1 -> wb_valid=0, rf_we=0.
- instret wrap: force count to FFFF_FFFF_FFFF_FFFF, capture one valid instruction -> 0.
